// File: rtl/case_4_mul_arbiter.sv
// Round-robin arbiter that time-shares one zero-latency signed multiplier among
// NUM_REQ requesters and returns each product with the winning requester's index.
module case_4_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DIN0_W  = 10,
    parameter int DIN1_W  = 7,
    parameter int DOUT_W  = 10
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DIN0_W-1:0]   req_a,
    input  logic [NUM_REQ*DIN1_W-1:0]   req_b,
    output logic [DIN0_W-1:0]           mul_din0,
    output logic [DIN1_W-1:0]           mul_din1,
    input  logic [DOUT_W-1:0]           mul_dout,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [DOUT_W-1:0]           res_data,
    output logic [$clog2(NUM_REQ)-1:0]  res_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [ID_W:0]   NREQ_EXT = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DIN0_W-1:0] din0_q, din0_d;
    logic [DIN1_W-1:0] din1_q, din1_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              res_valid_q, res_valid_d;
    logic [DOUT_W-1:0] res_data_q, res_data_d;

    logic [ID_W-1:0]   cand_idx [NUM_REQ];
    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;
    logic              can_grant;
    logic              grant_fire;

    // cand_idx[k] is the requester examined k-th, counting up from rr_ptr modulo NUM_REQ
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            localparam logic [ID_W:0] OFS = (ID_W+1)'(gi);
            logic [ID_W:0] sum;
            logic [ID_W:0] wrapped;
            assign sum     = {1'b0, rr_ptr_q} + OFS;
            assign wrapped = sum - NREQ_EXT;
            assign cand_idx[gi] = (sum >= NREQ_EXT) ? wrapped[ID_W-1:0] : sum[ID_W-1:0];
        end
    endgenerate

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && req_valid[cand_idx[k]]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx[k];
            end
        end
    end

    // A HOLD handshake frees the multiplier in the same cycle, so a new grant may overlap it
    assign can_grant  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && res_ready);
    assign grant_fire = can_grant && grant_vld;
    assign req_ready  = (grant_fire && !ap_rst) ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        din0_d      = din0_q;
        din1_d      = din1_q;
        id_d        = id_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                res_data_d  = mul_dout;
                res_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = grant_vld ? ST_MUL : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (grant_fire) begin
            din0_d   = req_a[int'(grant_idx)*DIN0_W +: DIN0_W];
            din1_d   = req_b[int'(grant_idx)*DIN1_W +: DIN1_W];
            id_d     = grant_idx;
            rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + ID_W'(1);
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            din0_q      <= '0;
            din1_q      <= '0;
            id_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            din0_q      <= din0_d;
            din1_q      <= din1_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign mul_din0  = din0_q;
    assign mul_din1  = din1_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = id_q;

endmodule

// File: tb/tb_case_4_mul_arbiter.sv
// Bench for case_4_mul_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model (one slot in flight, one result held).
module tb_case_4_mul_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int BW = 7;
    localparam int DW = 10;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_a;
    logic [N*BW-1:0]   req_b;
    logic [AW-1:0]     mul_din0;
    logic [BW-1:0]     mul_din1;
    logic [DW-1:0]     mul_dout;
    logic              res_valid;
    logic              res_ready;
    logic [DW-1:0]     res_data;
    logic [1:0]        res_id;

    case_4_mul_arbiter #(
        .NUM_REQ (N),
        .DIN0_W  (AW),
        .DIN1_W  (BW),
        .DOUT_W  (DW)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    always #5 ap_clk = ~ap_clk;

    // Shared zero-stage multiplier
    logic signed [16:0] full_prod;
    assign full_prod = $signed(mul_din0) * $signed(mul_din1);
    assign mul_dout  = full_prod[DW-1:0];

    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference state
    int          m_ptr;
    bit          m_infl;
    logic [9:0]  m_infl_data;
    int          m_infl_id;
    bit          m_held;
    logic [9:0]  m_held_data;
    int          m_held_id;
    logic [9:0]  m_last_a;
    logic [6:0]  m_last_b;
    int          cyc = 0;
    int          hs_cnt = 0;
    int          g_idx[$];
    int          g_cyc[$];

    function automatic logic [9:0] ref_prod(input logic [9:0] a, input logic [6:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[9:0];
    endfunction

    task automatic model_reset();
        m_ptr    = 0;
        m_infl   = 1'b0;
        m_held   = 1'b0;
        m_last_a = '0;
        m_last_b = '0;
    endtask

    task automatic set_op(input int i, input logic [9:0] a, input logic [6:0] b);
        req_a[i*AW +: AW] = a;
        req_b[i*BW +: BW] = b;
    endtask

    // One clock cycle: compare at the falling edge, then advance the model across the rising edge
    task automatic step();
        logic [N-1:0] exp_rdy;
        int w;
        int idx;
        @(negedge ap_clk);
        w = -1;
        if (!m_infl && (!m_held || res_ready)) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (w < 0 && req_valid[idx]) w = idx;
            end
        end
        exp_rdy = (w >= 0) ? N'(1 << w) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("res_valid", 32'(res_valid), 32'(m_held));
        if (m_held) begin
            chk("res_data", 32'(res_data), 32'(m_held_data));
            chk("res_id", 32'(res_id), 32'(m_held_id));
        end
        chk("mul_din0", 32'(mul_din0), 32'(m_last_a));
        chk("mul_din1", 32'(mul_din1), 32'(m_last_b));
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                g_idx.push_back(i);
                g_cyc.push_back(cyc);
                $display("cyc %0d grant req=%0d a=%0d b=%0d", cyc, i,
                         $signed(req_a[i*AW +: AW]), $signed(req_b[i*BW +: BW]));
            end
        end
        if (res_valid && res_ready) begin
            hs_cnt++;
            $display("cyc %0d result id=%0d data=%0d", cyc, res_id, $signed(res_data));
        end
        if (m_held && res_ready) m_held = 1'b0;
        if (m_infl) begin
            m_held      = 1'b1;
            m_held_data = m_infl_data;
            m_held_id   = m_infl_id;
            m_infl      = 1'b0;
        end
        if (w >= 0) begin
            m_last_a    = req_a[w*AW +: AW];
            m_last_b    = req_b[w*BW +: BW];
            m_infl      = 1'b1;
            m_infl_data = ref_prod(m_last_a, m_last_b);
            m_infl_id   = w;
            m_ptr       = (w + 1) % N;
        end
        cyc++;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst    = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        @(posedge ap_clk);
        #1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        model_reset();
    endtask

    int exp_ord[5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] bp_data;
    logic [1:0]    bp_id;

    initial begin
        // Reset state, with requests already pending
        ap_rst    = 1'b1;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, 10'($urandom), 7'($urandom));
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_res_data", 32'(res_data), 32'h0);
        chk("rst_res_id", 32'(res_id), 32'h0);
        chk("rst_mul_din0", 32'(mul_din0), 32'h0);
        chk("rst_mul_din1", 32'(mul_din1), 32'h0);
        repeat (2) @(posedge ap_clk);
        #1;
        chk("rst_req_ready_edge", 32'(req_ready), 32'h0);
        model_reset();

        // Single request: 12 * -5 = -60, first grant on the first edge after release
        req_valid = 4'b0001;
        set_op(0, 10'd12, 7'h7B);
        ap_rst = 1'b0;
        #3;
        chk("single_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        step();
        chk("single_valid", 32'(res_valid), 32'h1);
        chk("single_data", 32'(res_data), 32'h3C4);
        chk("single_id", 32'(res_id), 32'h0);
        repeat (2) step();

        // Fairness: all four requesting continuously
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 10'($urandom), 7'($urandom));
        req_valid = 4'b1111;
        res_ready = 1'b1;
        g_idx.delete();
        g_cyc.delete();
        repeat (10) step();
        chk("fair_count", 32'(g_idx.size()), 32'd5);
        for (int k = 0; k < 5 && k < g_idx.size(); k++) begin
            chk("fair_order", 32'(g_idx[k]), 32'(exp_ord[k]));
            if (k > 0) chk("fair_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'd2);
        end

        // Backpressure: result held stable, no grants while stalled
        do_reset();
        set_op(0, 10'($urandom), 7'($urandom));
        req_valid = 4'b0001;
        res_ready = 1'b0;
        step();
        req_valid = 4'b1111;
        step();
        chk("bp_valid_first", 32'(res_valid), 32'h1);
        bp_data = res_data;
        bp_id   = res_id;
        repeat (5) begin
            step();
            chk("bp_valid", 32'(res_valid), 32'h1);
            chk("bp_data", 32'(res_data), 32'(bp_data));
            chk("bp_id", 32'(res_id), 32'(bp_id));
            chk("bp_ready", 32'(req_ready), 32'h0);
        end
        res_ready = 1'b1;
        req_valid = 4'b0000;
        hs_cnt    = 0;
        repeat (4) step();
        chk("bp_delivered", 32'(hs_cnt), 32'd1);

        // Wrap: -512 * -64 = 32768 -> low 10 bits 0
        req_valid = 4'b0100;
        set_op(2, 10'h200, 7'h40);
        step();
        req_valid = 4'b0000;
        step();
        chk("wrap_valid", 32'(res_valid), 32'h1);
        chk("wrap_data", 32'(res_data), 32'h0);
        chk("wrap_id", 32'(res_id), 32'h2);
        step();

        // Boundary: 511 * 63 = 32193 -> 449
        req_valid = 4'b1000;
        set_op(3, 10'h1FF, 7'h3F);
        step();
        req_valid = 4'b0000;
        step();
        chk("bound_valid", 32'(res_valid), 32'h1);
        chk("bound_data", 32'(res_data), 32'h1C1);
        chk("bound_id", 32'(res_id), 32'h3);
        step();

        // Reset during MUL after moving the pointer away from 0
        req_valid = 4'b0010;
        set_op(1, 10'($urandom), 7'($urandom));
        step();
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_op(i, 10'($urandom), 7'($urandom));
        #3;
        ap_rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(res_valid), 32'h0);
        chk("midrst_ready", 32'(req_ready), 32'h0);
        chk("midrst_data", 32'(res_data), 32'h0);
        chk("midrst_id", 32'(res_id), 32'h0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        model_reset();
        #3;
        chk("midrst_first_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        step();
        chk("midrst_res_valid", 32'(res_valid), 32'h1);
        chk("midrst_res_id", 32'(res_id), 32'h0);
        step();

        // Random traffic
        repeat (400) begin
            req_valid = 4'($urandom);
            for (int i = 0; i < N; i++) set_op(i, 10'($urandom), 7'($urandom));
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        res_ready = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
